// File: rtl/tpu_tile_scheduler_if.sv
// Tile command channel between the GEMM tile scheduler and the TPU core.
// Scheduler drives the command fields; the TPU answers with iss_ready.
interface tpu_tile_scheduler_if #(
  parameter int DIM_W  = 5,
  parameter int ADDR_W = 8
);
  logic              iss_valid;
  logic              iss_ready;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] base_o;
  logic [DIM_W-1:0]  k_len;
  logic [DIM_W-1:0]  rows;
  logic [DIM_W-1:0]  cols;

  modport master (
    output iss_valid,
    output base_a,
    output base_b,
    output base_o,
    output k_len,
    output rows,
    output cols,
    input  iss_ready
  );

  modport slave (
    input  iss_valid,
    input  base_a,
    input  base_b,
    input  base_o,
    input  k_len,
    input  rows,
    input  cols,
    output iss_ready
  );
endinterface

// File: rtl/tpu_tile_scheduler.sv
// Walks a GEMM tile by tile through the systolic TPU (row-major tiles).
// Optional busy-cycle counter: define TILE_SCHED_PERF_CNT_EN.
module tpu_tile_scheduler #(
  parameter int TILE   = 4,
  parameter int DIM_W  = 5,
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] m,
  input  logic [DIM_W-1:0] n,
  input  logic [DIM_W-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  tpu_tile_scheduler_if.master iss,
  input  logic             tpu_done,
  output logic [15:0]      cycle_cnt
);

  localparam int TW = $clog2(TILE);

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    ISSUE,
    WAIT,
    NEXT,
    FIN
  } state_t;

  state_t state;

  logic [DIM_W-1:0]  m_q;
  logic [DIM_W-1:0]  n_q;
  logic [DIM_W-1:0]  k_q;
  logic [DIM_W-1:0]  mt;
  logic [DIM_W-1:0]  nt;
  logic [DIM_W-1:0]  r;
  logic [DIM_W-1:0]  c;

  logic [DIM_W-1:0]  nr;
  logic [DIM_W-1:0]  nc;
  logic [ADDR_W-1:0] na;
  logic [ADDR_W-1:0] nb;
  logic [ADDR_W-1:0] no;
  logic [DIM_W-1:0]  nrows;
  logic [DIM_W-1:0]  ncols;
  logic              last_c;
  logic              last_t;
  logic              bad;

  function automatic logic [DIM_W-1:0] tiles(
    input logic [DIM_W-1:0] d
  );
    logic [DIM_W:0] s;
    s = {1'b0, d} + (DIM_W+1)'(TILE - 1);
    return DIM_W'(s >> TW);
  endfunction

  function automatic logic [DIM_W-1:0] edge_sz(
    input logic [DIM_W-1:0] d,
    input logic [DIM_W-1:0] idx
  );
    logic [DIM_W-1:0] rem;
    rem = d - DIM_W'(idx << TW);
    return (rem >= DIM_W'(TILE)) ? DIM_W'(TILE) : rem;
  endfunction

  assign bad    = (m == '0) || (n == '0) || (k == '0);
  assign last_c = (c == nt - DIM_W'(1));
  assign last_t = last_c && (r == mt - DIM_W'(1));

  // CFG targets tile 0; NEXT targets the successor of (r, c).
  always_comb begin
    nr = '0;
    nc = '0;
    if (state != CFG) begin
      nc = last_c ? '0 : c + DIM_W'(1);
      nr = last_c ? r + DIM_W'(1) : r;
    end
    na    = ADDR_W'(nr) * ADDR_W'(k_q);
    nb    = ADDR_W'(nc) * ADDR_W'(k_q);
    no    = (ADDR_W'(nr) * ADDR_W'(nt) + ADDR_W'(nc)) << TW;
    nrows = edge_sz(m_q, nr);
    ncols = edge_sz(n_q, nc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
      m_q           <= '0;
      n_q           <= '0;
      k_q           <= '0;
      mt            <= '0;
      nt            <= '0;
      r             <= '0;
      c             <= '0;
      iss.iss_valid <= 1'b0;
      iss.base_a    <= '0;
      iss.base_b    <= '0;
      iss.base_o    <= '0;
      iss.k_len     <= '0;
      iss.rows      <= '0;
      iss.cols      <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && bad) begin
            cfg_err <= 1'b1;
          end else if (start) begin
            m_q   <= m;
            n_q   <= n;
            k_q   <= k;
            r     <= '0;
            c     <= '0;
            busy  <= 1'b1;
            state <= CFG;
          end
        end
        CFG: begin
          mt            <= tiles(m_q);
          nt            <= tiles(n_q);
          iss.base_a    <= na;
          iss.base_b    <= nb;
          iss.base_o    <= no;
          iss.k_len     <= k_q;
          iss.rows      <= nrows;
          iss.cols      <= ncols;
          iss.iss_valid <= 1'b1;
          state         <= ISSUE;
        end
        ISSUE: begin
          if (iss.iss_ready) begin
            iss.iss_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (tpu_done) state <= NEXT;
        end
        NEXT: begin
          if (last_t) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            r             <= nr;
            c             <= nc;
            iss.base_a    <= na;
            iss.base_b    <= nb;
            iss.base_o    <= no;
            iss.rows      <= nrows;
            iss.cols      <= ncols;
            iss.iss_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TILE_SCHED_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (state == IDLE && start && !bad) begin
      cycle_cnt <= '0;
    end else if (busy && cycle_cnt != 16'hFFFF) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Directed bench for tpu_tile_scheduler.
// All inputs change and outputs are sampled on the falling edge.
module tb_tpu_tile_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  m;
  logic [4:0]  n;
  logic [4:0]  k;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic        tpu_done;
  logic [15:0] cycle_cnt;

  int n_chk;
  int n_pass;

  tpu_tile_scheduler_if #(.DIM_W(5), .ADDR_W(8)) bus ();

  tpu_tile_scheduler #(
    .TILE(4),
    .DIM_W(5),
    .ADDR_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .m(m),
    .n(n),
    .k(k),
    .busy(busy),
    .done(done),
    .cfg_err(cfg_err),
    .iss(bus),
    .tpu_done(tpu_done),
    .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic start_gemm(
    input logic [4:0] mm,
    input logic [4:0] nn,
    input logic [4:0] kk
  );
    m     = mm;
    n     = nn;
    k     = kk;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_tile(
    input string      tag,
    input logic [7:0] ea,
    input logic [7:0] eb,
    input logic [7:0] eo,
    input logic [4:0] er,
    input logic [4:0] ec,
    input logic [4:0] ek,
    input int         stall,
    input bit         sw,
    input bit         rw
  );
    int w;
    w = 0;
    while (!bus.iss_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, ".vld"}, 32'(bus.iss_valid), 1);
    if (!bus.iss_valid) return;
    check({tag, ".lat"}, w, 1);
    check({tag, ".a"}, 32'(bus.base_a), 32'(ea));
    check({tag, ".b"}, 32'(bus.base_b), 32'(eb));
    check({tag, ".o"}, 32'(bus.base_o), 32'(eo));
    check({tag, ".rows"}, 32'(bus.rows), 32'(er));
    check({tag, ".cols"}, 32'(bus.cols), 32'(ec));
    check({tag, ".klen"}, 32'(bus.k_len), 32'(ek));
    if (stall > 0) begin
      tpu_done = 1'b1;
      @(negedge clk);
      tpu_done = 1'b0;
      repeat (stall - 1) @(negedge clk);
      check({tag, ".hold_v"}, 32'(bus.iss_valid), 1);
      check({tag, ".hold_a"}, 32'(bus.base_a), 32'(ea));
      check({tag, ".hold_o"}, 32'(bus.base_o), 32'(eo));
      check({tag, ".hold_c"}, 32'(bus.cols), 32'(ec));
    end
    bus.iss_ready = 1'b1;
    @(negedge clk);
    bus.iss_ready = 1'b0;
    check({tag, ".drop"}, 32'(bus.iss_valid), 0);
    @(negedge clk);
    if (rw) begin
      rst_n = 1'b0;
      #1;
      check({tag, ".rst_busy"}, 32'(busy), 0);
      check({tag, ".rst_vld"}, 32'(bus.iss_valid), 0);
      check({tag, ".rst_a"}, 32'(bus.base_a), 0);
      check({tag, ".rst_o"}, 32'(bus.base_o), 0);
      check({tag, ".rst_rows"}, 32'(bus.rows), 0);
      check({tag, ".rst_klen"}, 32'(bus.k_len), 0);
      check({tag, ".rst_done"}, 32'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    if (sw) begin
      m     = 5'd1;
      n     = 5'd1;
      k     = 5'd1;
      start = 1'b1;
    end
    @(negedge clk);
    start    = 1'b0;
    tpu_done = 1'b1;
    @(negedge clk);
    tpu_done = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit sf);
    int w;
    w = 0;
    while (!done && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, ".done"}, 32'(done), 1);
    check({tag, ".lat"}, w, 1);
    check({tag, ".busy_fin"}, 32'(busy), 1);
    if (sf) begin
      m     = 5'd4;
      n     = 5'd4;
      k     = 5'd4;
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, ".done_off"}, 32'(done), 0);
    check({tag, ".busy_off"}, 32'(busy), 0);
    @(negedge clk);
    check({tag, ".idle"}, 32'(busy), 0);
    check({tag, ".no_vld"}, 32'(bus.iss_valid), 0);
  endtask

  initial begin
    n_chk         = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    start         = 1'b0;
    m             = '0;
    n             = '0;
    k             = '0;
    tpu_done      = 1'b0;
    bus.iss_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.err", 32'(cfg_err), 0);
    check("rst.vld", 32'(bus.iss_valid), 0);
    check("rst.a", 32'(bus.base_a), 0);
    check("rst.rows", 32'(bus.rows), 0);
    check("rst.cnt", 32'(cycle_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single tile, exact cycle timing
    bus.iss_ready = 1'b1;
    start_gemm(5'd4, 5'd4, 5'd4);
    check("t1.busy", 32'(busy), 1);
    check("t1.cfg_vld", 32'(bus.iss_valid), 0);
    @(negedge clk);
    check("t1.vld", 32'(bus.iss_valid), 1);
    check("t1.a", 32'(bus.base_a), 0);
    check("t1.o", 32'(bus.base_o), 0);
    check("t1.rows", 32'(bus.rows), 4);
    check("t1.cols", 32'(bus.cols), 4);
    @(negedge clk);
    bus.iss_ready = 1'b0;
    check("t1.wait_vld", 32'(bus.iss_valid), 0);
    @(negedge clk);
    @(negedge clk);
    tpu_done = 1'b1;
    @(negedge clk);
    tpu_done = 1'b0;
    check("t1.early_done", 32'(done), 0);
    @(negedge clk);
    check("t1.done", 32'(done), 1);
    @(negedge clk);
    check("t1.done_off", 32'(done), 0);
    check("t1.busy_off", 32'(busy), 0);
`ifdef TILE_SCHED_PERF_CNT_EN
    check("t1.cnt", 32'(cycle_cnt), 7);
`else
    check("t1.cnt", 32'(cycle_cnt), 0);
`endif

    // 2x2 tiles, stalled ready, start in WAIT and in FIN
    start_gemm(5'd8, 5'd8, 5'd4);
    do_tile("g8.t0", 8'd0, 8'd0, 8'd0, 5'd4, 5'd4, 5'd4, 5, 0, 0);
    do_tile("g8.t1", 8'd0, 8'd4, 8'd4, 5'd4, 5'd4, 5'd4, 0, 1, 0);
    do_tile("g8.t2", 8'd4, 8'd0, 8'd8, 5'd4, 5'd4, 5'd4, 0, 0, 0);
    do_tile("g8.t3", 8'd4, 8'd4, 8'd12, 5'd4, 5'd4, 5'd4, 0, 0, 0);
    wait_done("g8", 1);

    // partial edge tiles
    start_gemm(5'd5, 5'd6, 5'd3);
    do_tile("g5.t0", 8'd0, 8'd0, 8'd0, 5'd4, 5'd4, 5'd3, 0, 0, 0);
    do_tile("g5.t1", 8'd0, 8'd3, 8'd4, 5'd4, 5'd2, 5'd3, 0, 0, 0);
    do_tile("g5.t2", 8'd3, 8'd0, 8'd8, 5'd1, 5'd4, 5'd3, 0, 0, 0);
    do_tile("g5.t3", 8'd3, 8'd3, 8'd12, 5'd1, 5'd2, 5'd3, 0, 0, 0);
    wait_done("g5", 0);

    // zero dimension
    start_gemm(5'd4, 5'd4, 5'd0);
    check("err.pulse", 32'(cfg_err), 1);
    check("err.busy", 32'(busy), 0);
    @(negedge clk);
    check("err.off", 32'(cfg_err), 0);
    check("err.idle", 32'(busy), 0);

    // reset during WAIT of tile 2, then a clean rerun
    start_gemm(5'd8, 5'd8, 5'd4);
    do_tile("rs.t0", 8'd0, 8'd0, 8'd0, 5'd4, 5'd4, 5'd4, 0, 0, 0);
    do_tile("rs.t1", 8'd0, 8'd4, 8'd4, 5'd4, 5'd4, 5'd4, 0, 0, 0);
    do_tile("rs.t2", 8'd4, 8'd0, 8'd8, 5'd4, 5'd4, 5'd4, 0, 0, 1);
    repeat (4) @(negedge clk);
    check("rs.no_done", 32'(done), 0);
    check("rs.idle", 32'(busy), 0);
    start_gemm(5'd8, 5'd8, 5'd4);
    do_tile("rr.t0", 8'd0, 8'd0, 8'd0, 5'd4, 5'd4, 5'd4, 0, 0, 0);
    do_tile("rr.t1", 8'd0, 8'd4, 8'd4, 5'd4, 5'd4, 5'd4, 0, 0, 0);
    do_tile("rr.t2", 8'd4, 8'd0, 8'd8, 5'd4, 5'd4, 5'd4, 0, 0, 0);
    do_tile("rr.t3", 8'd4, 8'd4, 8'd12, 5'd4, 5'd4, 5'd4, 0, 0, 0);
    wait_done("rr", 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
